// File: rtl/cook_timer.sv
// Cook timer: counts a BCD m:ss cook time down once per TICK_CYCLES clocks.
// The cook time is chosen from four presets by `mode` while idle. Countdown can
// be paused and resumed, and it is cancelled whenever `idle` is high.
// Reaching 0:00 gives a single registered timerEnd pulse and parks in DONE.
//
// Handshake: start and idle are levels, sampled on every rising clk edge.
// idle=1 always wins: it cancels RUN, PAUSE or DONE, even in the same cycle as
// the final tick. start=1 with idle=0 runs the countdown. start=0 with idle=0
// pauses it.
module cook_timer #(
    parameter int          TICK_CYCLES = 100000000,
    parameter logic [11:0] PRESET0     = 12'h030,
    parameter logic [11:0] PRESET1     = 12'h100,
    parameter logic [11:0] PRESET2     = 12'h200,
    parameter logic [11:0] PRESET3     = 12'h500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       idle,
    output logic       timerEnd,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [11:0]   rem, rem_nx;
    logic [PW-1:0] presc, presc_nx;
    logic          end_nx;
    logic [11:0]   preset_sel;

    // Subtract one second from a {min, sec_tens, sec_ones} BCD value.
    // Callers never pass 0:00.
    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [3:0] m, tn, on;
        m  = t[11:8];
        tn = t[7:4];
        on = t[3:0];
        if (on != 4'd0) begin
            on = on - 4'd1;
        end else begin
            on = 4'd9;
            if (tn != 4'd0) begin
                tn = tn - 4'd1;
            end else begin
                tn = 4'd5;
                m  = m - 4'd1;
            end
        end
        return {m, tn, on};
    endfunction

    // Preset lookup for the currently selected mode.
    always_comb begin
        case (mode)
            2'd0:    preset_sel = PRESET0;
            2'd1:    preset_sel = PRESET1;
            2'd2:    preset_sel = PRESET2;
            default: preset_sel = PRESET3;
        endcase
    end

    // Next-state and datapath decisions. idle is checked before start, the
    // zero-time check and the tick.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        presc_nx = presc;
        end_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                rem_nx = preset_sel;
                if (start && !idle) begin
                    state_nx = S_RUN;
                    presc_nx = '0;
                end
            end
            S_RUN: begin
                if (idle) begin
                    state_nx = S_IDLE;
                end else if (rem == 12'h000) begin
                    // A zero preset finishes at once, without a tick.
                    state_nx = S_DONE;
                    end_nx   = 1'b1;
                end else if (!start) begin
                    state_nx = S_PAUSE;
                end else if (presc == PRESC_LAST) begin
                    presc_nx = '0;
                    if (rem == 12'h001) begin
                        rem_nx   = 12'h000;
                        end_nx   = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        rem_nx = bcd_dec(rem);
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (idle) begin
                    state_nx = S_IDLE;
                end else if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_DONE: begin
                if (idle) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, remaining time, prescaler and the registered end pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rem      <= PRESET0;
            presc    <= '0;
            timerEnd <= 1'b0;
        end else begin
            state    <= state_nx;
            rem      <= rem_nx;
            presc    <= presc_nx;
            timerEnd <= end_nx;
        end
    end

    assign min_bcd   = rem[11:8];
    assign sec_tens  = rem[7:4];
    assign sec_ones  = rem[3:0];
    assign running   = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer with TICK_CYCLES=4. Stimulus pushes each expected
// observation with the cycle it is due. A negedge monitor pops and compares it.
// The observation packs {timerEnd, running, done, min, sec_tens, sec_ones}.
module tb_cook_timer;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       start;
    logic       idle;
    logic       timerEnd;
    logic [3:0] min_bcd;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
    logic [1:0] state_dbg;

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;

    logic [14:0] exp_q[$];
    logic [14:0] mask_q[$];
    int          cyc_q[$];
    string       name_q[$];

    localparam logic [14:0] FULL = 15'h7FFF;
    localparam logic [14:0] FLAGS = 15'h7000;

    cook_timer #(.TICK_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .start    (start),
        .idle     (idle),
        .timerEnd (timerEnd),
        .min_bcd  (min_bcd),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model of the cook time presets.
    function automatic logic [11:0] preset(input int m);
        case (m)
            0:       return 12'h030;
            1:       return 12'h100;
            2:       return 12'h200;
            default: return 12'h500;
        endcase
    endfunction

    // Seconds to {min, tens, ones} BCD.
    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [14:0] pk(input logic te, input logic rn,
                                      input logic dn, input logic [11:0] t);
        return {te, rn, dn, t};
    endfunction

    task automatic expect_at(input int c, input logic [14:0] v,
                             input logic [14:0] m, input string n);
        cyc_q.push_back(c);
        exp_q.push_back(v);
        mask_q.push_back(m);
        name_q.push_back(n);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        logic [14:0] obs;
        logic [14:0] e;
        logic [14:0] m;
        int          c;
        string       n;
        obs = {timerEnd, running, done, min_bcd, sec_tens, sec_ones};
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            c = cyc_q.pop_front();
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (c < cyc) begin
                fails++;
                $display("FAIL %s: check due at cycle %0d was missed (now %0d)", n, c, cyc);
            end else if ((obs & m) !== (e & m)) begin
                fails++;
                $display("FAIL %s: cycle %0d got %h expected %h (mask %h)", n, cyc, obs, e, m);
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int c;
        rst   = 1'b0;
        mode  = 2'd0;
        start = 1'b0;
        idle  = 1'b1;

        // Reset holds PRESET0 and clears the flags.
        step(2);
        expect_at(cyc, pk(0, 0, 0, 12'h030), FULL, "reset_hold");
        step(1);
        rst = 1'b1;
        step(2);
        expect_at(cyc, pk(0, 0, 0, 12'h030), FULL, "idle_after_reset");

        // Mode stepping in IDLE: display follows one cycle later.
        for (int m = 1; m <= 4; m++) begin
            mode = 2'(m % 4);
            expect_at(cyc + 1, pk(0, 0, 0, preset(m % 4)), FULL, "mode_follow");
            step(1);
        end

        // Full countdown from 0:30 to 0:00 with one end pulse.
        c = cyc;
        start = 1'b1;
        idle  = 1'b0;
        for (int k = 0; k < 30; k++)
            expect_at(c + 1 + 4 * k, pk(0, 1, 0, to_bcd(30 - k)), FULL, "count_030");
        expect_at(c + 121, pk(1, 0, 1, 12'h000), FULL, "end_pulse");
        expect_at(c + 122, pk(0, 0, 1, 12'h000), FULL, "end_single");
        expect_at(c + 130, pk(0, 0, 1, 12'h000), FULL, "done_ignores_start");
        step(131);
        start = 1'b0;
        idle  = 1'b1;
        expect_at(cyc + 2, pk(0, 0, 0, 12'h030), FULL, "done_to_idle");
        step(3);

        // Pause at 0:57 with the prescaler at 1, then resume.
        mode = 2'd1;
        step(2);
        c = cyc;
        start = 1'b1;
        idle  = 1'b0;
        expect_at(c + 1, pk(0, 1, 0, 12'h100), FULL, "run_100");
        expect_at(c + 13, pk(0, 1, 0, 12'h057), FULL, "run_057");
        step(14);
        start = 1'b0;
        expect_at(c + 15, pk(0, 0, 0, 12'h057), FULL, "pause_enter");
        expect_at(c + 34, pk(0, 0, 0, 12'h057), FULL, "pause_hold");
        step(20);
        start = 1'b1;
        expect_at(c + 35, pk(0, 1, 0, 12'h057), FULL, "resume");
        expect_at(c + 37, pk(0, 1, 0, 12'h057), FULL, "resume_wait");
        expect_at(c + 38, pk(0, 1, 0, 12'h056), FULL, "resume_tick");
        step(5);
        start = 1'b0;
        idle  = 1'b1;
        expect_at(cyc + 2, pk(0, 0, 0, 12'h100), FULL, "cancel_to_idle");
        step(3);

        // 5:00 countdown, minute borrows, mode change ignored while running.
        mode = 2'd3;
        step(2);
        c = cyc;
        start = 1'b1;
        idle  = 1'b0;
        expect_at(c + 1, pk(0, 1, 0, 12'h500), FULL, "run_500");
        expect_at(c + 5, pk(0, 1, 0, 12'h459), FULL, "borrow_459");
        expect_at(c + 9, pk(0, 1, 0, 12'h458), FULL, "run_458");
        step(20);
        mode = 2'd0;
        expect_at(c + 21, pk(0, 1, 0, 12'h455), FULL, "mode_ignored_run");
        expect_at(c + 241, pk(0, 1, 0, 12'h400), FULL, "run_400");
        expect_at(c + 245, pk(0, 1, 0, 12'h359), FULL, "borrow_359");
        step(226);
        start = 1'b0;
        idle  = 1'b1;
        expect_at(cyc + 2, pk(0, 0, 0, 12'h030), FULL, "cancel_new_mode");
        step(3);

        // idle in the same cycle as the final tick: no pulse, back to IDLE.
        c = cyc;
        start = 1'b1;
        idle  = 1'b0;
        expect_at(c + 117, pk(0, 1, 0, 12'h001), FULL, "run_001");
        step(120);
        idle = 1'b1;
        expect_at(c + 121, pk(0, 0, 0, 12'h000), FLAGS, "idle_beats_end");
        expect_at(c + 122, pk(0, 0, 0, 12'h030), FULL, "idle_preset");
        expect_at(c + 123, pk(0, 0, 0, 12'h030), FULL, "idle_stays");
        step(4);
        start = 1'b0;
        step(1);

        // Asynchronous reset between clock edges mid-RUN.
        c = cyc;
        start = 1'b1;
        idle  = 1'b0;
        expect_at(c + 5, pk(0, 1, 0, 12'h029), FULL, "pre_reset_029");
        step(6);
        expect_at(cyc, pk(0, 0, 0, 12'h030), FULL, "async_reset");
        rst   = 1'b0;
        start = 1'b0;
        idle  = 1'b1;
        step(2);
        rst = 1'b1;
        expect_at(cyc + 1, pk(0, 0, 0, 12'h030), FULL, "after_reset_release");
        step(3);

        // Anything still queued was never compared.
        while (cyc_q.size() > 0) begin
            tests_run++;
            fails++;
            $display("FAIL %s: check due at cycle %0d never reached", name_q[0], cyc_q[0]);
            void'(cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(mask_q.pop_front());
            void'(name_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
